mem_stage: RTL and testbench

- Memory stage of the 8-bit pipeline.
- Holds the EX/MEM pipeline register and drives the 16x8 data memory port: write enable, address, write data, and combinational read data back.
- Registers the load or ALU result into the MEM/WB register for register-file write-back.
- Publishes MEM-stage load and destination info to the hazard unit.

---
 rtl/mem_stage.sv | 119 +++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 8-bit pipeline: EX/MEM and MEM/WB registers plus data-memory drive.
// Optional address-range checking is enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_di,
  input  logic [DATA_W-1:0] dm_do,
  output logic              mem_is_load,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_fault
);

  logic              m_valid;
  logic              m_mem_read;
  logic              m_mem_write;
  logic              m_reg_write;
  logic [REG_AW-1:0] m_rd;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_store_data;
  logic              addr_fault;
  logic [DATA_W-1:0] wb_next_data;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (data fields included) is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid      <= 1'b0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_reg_write  <= 1'b0;
      m_rd         <= '0;
      m_alu_result <= '0;
      m_store_data <= '0;
    end else if (!stall) begin
      if (flush) begin
        // Bubble: controls cleared, data fields simply hold.
        m_valid     <= 1'b0;
        m_mem_read  <= 1'b0;
        m_mem_write <= 1'b0;
        m_reg_write <= 1'b0;
      end else begin
        m_valid      <= ex_valid;
        m_mem_read   <= ex_mem_read;
        m_mem_write  <= ex_mem_write;
        m_reg_write  <= ex_reg_write;
        m_rd         <= ex_rd;
        m_alu_result <= ex_alu_result;
        m_store_data <= ex_store_data;
      end
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  logic fault_q;

  assign addr_fault = m_valid & (m_mem_read | m_mem_write) &
                      (|m_alu_result[DATA_W-1:ADDR_W]);

  always_ff @(posedge clk) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (addr_fault && !stall)
      fault_q <= 1'b1;
  end

  assign mem_fault = fault_q;
`else
  assign addr_fault = 1'b0;
  assign mem_fault  = 1'b0;
`endif

  // Stall gates the enable so a held store commits exactly once.
  assign dm_we       = m_valid & m_mem_write & ~stall & ~addr_fault;
  assign dm_addr     = m_alu_result[ADDR_W-1:0];
  assign dm_di       = m_store_data;
  assign mem_is_load = m_valid & m_mem_read;
  assign mem_rd      = m_rd;

  // NOTE: default assigned first so no latch is inferred.
  always_comb begin
    wb_next_data = m_alu_result;
    if (m_mem_read)
      wb_next_data = addr_fault ? '0 : dm_do;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else if (!stall) begin
      wb_valid     <= m_valid;
      wb_reg_write <= m_valid & m_reg_write;
      wb_rd        <= m_rd;
      wb_data      <= wb_next_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs, a monitor pops them.
// Fault expectations follow MEM_ADDR_CHECK_EN.
module tb_mem_stage;

  typedef struct {
    logic       rw;
    logic [2:0] rd;
    logic [7:0] data;
  } wb_exp_t;

  logic       clk;
  logic       rst_n;
  logic       ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0] ex_rd;
  logic [7:0] ex_alu_result, ex_store_data;
  logic       stall, flush;
  logic       dm_we;
  logic [3:0] dm_addr;
  logic [7:0] dm_di, dm_do;
  logic       mem_is_load;
  logic [2:0] mem_rd;
  logic       wb_valid, wb_reg_write;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       mem_fault;

  logic [7:0] mem [16];
  int         writes = 0;
  int         checks = 0;
  int         failures = 0;
  wb_exp_t    sb [$];
  logic       fault_exp;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_do(dm_do),
    .mem_is_load(mem_is_load), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  assign dm_do = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_we === 1'b1) begin
      mem[dm_addr] <= dm_di;
      writes       <= writes + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic [2:0] rd, input logic [7:0] alu, input logic [7:0] sd);
    ex_valid      = v;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_store_data = sd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic expect_wb(input logic rw, input logic [2:0] rd, input logic [7:0] data);
    wb_exp_t e;
    e.rw   = rw;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {1'b0, dm_we, dm_addr, dm_di, mem_is_load, mem_rd, wb_valid,
                 wb_reg_write, wb_rd, wb_data, mem_fault}, 32'h0);
  endtask

  // Monitor: a MEM/WB capture happens on every non-reset, non-stalled edge.
  initial begin
    logic    adv;
    wb_exp_t e;
    forever begin
      @(posedge clk);
      adv = (rst_n === 1'b1) && (stall === 1'b0);
      #1;
      if (adv && wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
          check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
          check("wb_data", {24'd0, wb_data}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int wr_before;
`ifdef MEM_ADDR_CHECK_EN
    fault_exp = 1'b1;
`else
    fault_exp = 1'b0;
`endif

    // Reset with random, valid-looking EX inputs.
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
            8'($urandom), 8'($urandom));
      tick();
      check_all_zero("reset_outputs");
    end
    rst_n = 1'b1;
    bubble();
    #1;
    check("dm_we_after_release", {31'd0, dm_we}, 32'd0);
    tick();

    // Store 0xA7 to 5, then load it back into r3.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h05, 8'hA7);
    expect_wb(1'b0, 3'd0, 8'h05);
    tick();
    check("store_dm_we", {31'd0, dm_we}, 32'd1);
    check("store_dm_addr", {28'd0, dm_addr}, 32'd5);
    check("store_dm_di", {24'd0, dm_di}, 32'hA7);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h05, 8'h00);
    expect_wb(1'b1, 3'd3, 8'hA7);
    tick();
    check("store_one_cycle", {31'd0, dm_we}, 32'd0);
    check("load_mem_is_load", {31'd0, mem_is_load}, 32'd1);
    check("load_mem_rd", {29'd0, mem_rd}, 32'd3);
    bubble();
    tick();
    check("store_write_count", writes, 32'd1);

    // ALU result 0x3C into r2.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h3C, 8'h00);
    expect_wb(1'b1, 3'd2, 8'h3C);
    tick();
    check("alu_dm_we", {31'd0, dm_we}, 32'd0);
    bubble();
    tick();
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);

    // Store 0x11 to 7 held by a three-cycle stall; a load to r6 waits in EX.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h07, 8'h11);
    expect_wb(1'b0, 3'd0, 8'h07);
    tick();
    wr_before = writes;
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 8'h07, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_dm_we", {31'd0, dm_we}, 32'd0);
      tick();
      check("stall_hold_addr", {28'd0, dm_addr}, 32'd7);
      check("stall_hold_di", {24'd0, dm_di}, 32'h11);
      check("stall_hold_is_load", {31'd0, mem_is_load}, 32'd0);
      check("stall_hold_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("stall_no_write", writes, wr_before);
    end
    stall = 1'b0;
    expect_wb(1'b1, 3'd6, 8'h11);
    #1;
    check("release_dm_we", {31'd0, dm_we}, 32'd1);
    tick();
    check("stall_store_once", writes, wr_before + 1);
    check("mem7", {24'd0, mem[7]}, 32'h11);
    check("after_store_dm_we", {31'd0, dm_we}, 32'd0);
    bubble();
    tick();

    // Load to r4, then flush under stall (ignored) and flush alone.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h07, 8'h00);
    expect_wb(1'b1, 3'd4, 8'h11);
    tick();
    check("flush_load_is_load", {31'd0, mem_is_load}, 32'd1);
    check("flush_load_rd", {29'd0, mem_rd}, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h99, 8'h00);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("flush_stall_is_load", {31'd0, mem_is_load}, 32'd1);
    check("flush_stall_rd", {29'd0, mem_rd}, 32'd4);
    stall = 1'b0;
    tick();
    check("flush_is_load", {31'd0, mem_is_load}, 32'd0);
    check("flush_dm_we", {31'd0, dm_we}, 32'd0);
    flush = 1'b0;
    bubble();
    tick();
    check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Out-of-range store to 0x25 and load from 0x35 into r1.
    wr_before = writes;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h25, 8'h5A);
    expect_wb(1'b0, 3'd0, 8'h25);
    tick();
    check("oor_dm_we", {31'd0, dm_we}, {31'd0, ~fault_exp});
    check("oor_fault_before_edge", {31'd0, mem_fault}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h35, 8'h00);
    expect_wb(1'b1, 3'd1, fault_exp ? 8'h00 : 8'h5A);
    tick();
    check("oor_fault_set", {31'd0, mem_fault}, {31'd0, fault_exp});
    check("oor_write_count", writes, wr_before + (fault_exp ? 0 : 1));
    bubble();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("oor_fault_sticky", {31'd0, mem_fault}, {31'd0, fault_exp});
    end
    if (!fault_exp)
      check("oor_wrap_mem5", {24'd0, mem[5]}, 32'h5A);

    rst_n = 1'b0;
    tick();
    check_all_zero("final_reset_outputs");
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
